// File: rtl/hs4_push_tx.sv
// hs4_push_tx: clocked valid/ready stream to 4-phase bundled-data req/ack bridge with a small FIFO
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data upstream word stream;
//        req/ack 4-phase handshake (ack asynchronous to clk), data_out bundled data;
//        busy = FIFO non-empty or handshake in progress; timeout_err sticky phase-timeout flag.
// Optional: define HS4_PUSH_TX_TIMEOUT_EN to build the handshake timeout counter; otherwise timeout_err is 0.
module hs4_push_tx #(
  parameter int WD = 4,
  parameter int DEPTH = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_data,
  output logic          req,
  input  logic          ack,
  output logic [WD-1:0] data_out,
  output logic          busy,
  output logic          timeout_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;
  state_t state;
  logic [WD-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic [SYNC_STAGES-1:0] sync;
  logic rdy, ack_s, full, empty, push, pop;
  assign ack_s = sync[SYNC_STAGES-1];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // rdy holds in_ready low through reset and for the edge that releases it
  assign in_ready = rdy & ~full;
  assign push = in_valid & in_ready;
  assign pop = (state == IDLE) & ~empty & ~ack_s;
  assign busy = ~empty | (state != IDLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy <= 1'b0;
      wp <= '0;
      rp <= '0;
      sync <= '0;
    end else begin
      rdy <= 1'b1;
      sync <= {sync[SYNC_STAGES-2:0], ack};
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= in_data;
  // data_out is loaded only on leaving IDLE, so it is stable for the whole handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          data_out <= mem[rp[AW-1:0]];
          state <= SETUP;
        end
        SETUP: begin
          req <= 1'b1;
          state <= REQ_HI;
        end
        REQ_HI: if (ack_s) begin
          req <= 1'b0;
          state <= REQ_LO;
        end
        REQ_LO: if (!ack_s) state <= IDLE;
      endcase
    end
`ifdef HS4_PUSH_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;
  logic err, enter, waiting;
  assign enter = (state == SETUP) | ((state == REQ_HI) & ack_s);
  assign waiting = ((state == REQ_HI) & ~ack_s) | ((state == REQ_LO) & ack_s);
  // err is set on the same edge the counter reaches TIMEOUT; the counter saturates there
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (enter) cnt <= '0;
      else if (waiting && cnt != TW'(TIMEOUT)) cnt <= cnt + TW'(1);
      if (waiting && cnt == TW'(TIMEOUT - 1)) err <= 1'b1;
    end
  assign timeout_err = err;
`else
  assign timeout_err = (TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_hs4_push_tx.sv
// tb_hs4_push_tx: directed scoreboard bench for hs4_push_tx with an automatic 4-phase responder
module tb_hs4_push_tx;
  localparam int WD = 4;
  localparam int DEPTH = 2;
  localparam int SS = 2;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [WD-1:0] in_data = '0;
  logic man_ack = 1'b0;
  logic resp_ack = 1'b0;
  logic ack;
  logic in_ready, req, busy, timeout_err;
  logic [WD-1:0] data_out;
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit resp_en = 1'b0;
  int resp_min = 3;
  int resp_max = 3;
  logic [WD-1:0] exp_q[$];

  assign ack = man_ack | resp_ack;
  always #5 clk = ~clk;

  hs4_push_tx #(.WD(WD), .DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .req(req),
    .ack(ack),
    .data_out(data_out),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // called at a negedge; returns at a negedge with in_valid dropped
  task automatic push(input logic [WD-1:0] w, input bit rec);
    int n = 0;
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", n < 200, 1);
    if (n < 200 && rec) exp_q.push_back(w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0 || ack) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  initial begin : responder
    logic [WD-1:0] held;
    int n;
    forever begin
      @(negedge clk);
      if (resp_en && req) begin
        held = data_out;
        check("queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("order", data_out, exp_q.pop_front());
        delivered++;
        repeat ($urandom_range(resp_max, resp_min)) @(negedge clk);
        resp_ack = 1'b1;
        n = 0;
        while (req && n < 100) begin
          check("stable", data_out, held);
          @(negedge clk);
          n++;
        end
        check("resp_req_fall", req, 0);
        repeat ($urandom_range(resp_max, resp_min)) @(negedge clk);
        resp_ack = 1'b0;
      end
    end
  end

  initial begin
    int n, d0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data_out, 0);
    check("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("ready_after_edge", in_ready, 1);

    in_valid = 1'b1;
    in_data = 4'hA;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_n_busy", busy, 1);
    check("lat_n_data", data_out, 0);
    check("lat_n_req", req, 0);
    @(negedge clk);
    check("lat_n1_data", data_out, 4'hA);
    check("lat_n1_req", req, 0);
    @(negedge clk);
    check("lat_n2_req", req, 1);
    check("lat_n2_data", data_out, 4'hA);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("req_hold_sync", req, 1);
    @(negedge clk);
    check("req_fall", req, 0);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_ack_lo_sync", busy, 1);
    @(negedge clk);
    check("busy_done", busy, 0);

    resp_en = 1'b0;
    push(4'h1, 1);
    push(4'h2, 1);
    push(4'h3, 1);
    repeat (3) @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_data", data_out, 4'h1);
    check("full_req", req, 1);
    in_valid = 1'b1;
    in_data = 4'h4;
    repeat (4) begin
      @(negedge clk);
      check("full_refuse", in_ready, 0);
    end
    in_valid = 1'b0;
    resp_min = 2;
    resp_max = 2;
    d0 = delivered;
    resp_en = 1'b1;
    wait_idle();
    check("fill_count", delivered - d0, 3);

    resp_min = 0;
    resp_max = 5;
    d0 = delivered;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      push(WD'(i), 1);
    end
    wait_idle();
    check("wrap_count", delivered - d0, 10);

    resp_en = 1'b0;
    man_ack = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push(4'h5, 1);
    repeat (6) @(negedge clk);
    check("stuck_req", req, 0);
    check("stuck_data", data_out, 0);
    check("stuck_busy", busy, 1);
    man_ack = 1'b0;
    repeat (SS + 1) @(negedge clk);
    check("stuck_req_pre", req, 0);
    @(negedge clk);
    check("stuck_req_rise", req, 1);
    check("stuck_data_rise", data_out, 4'h5);
    resp_min = 1;
    resp_max = 1;
    resp_en = 1'b1;
    wait_idle();

    resp_en = 1'b0;
    push(4'h7, 0);
    push(4'h8, 0);
    n = 0;
    while (!req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_req_up", req, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", in_ready, 1);
    check("mid_rel_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("mid_idle_req", req, 0);
    check("mid_idle_busy", busy, 0);
    d0 = delivered;
    resp_en = 1'b1;
    push(4'h9, 1);
    wait_idle();
    check("mid_count", delivered - d0, 1);

`ifdef HS4_PUSH_TX_TIMEOUT_EN
    check("to_clear", timeout_err, 0);
    resp_en = 1'b0;
    push(4'hC, 1);
    n = 0;
    while (!req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_req", req, 1);
    repeat (TO - 1) @(negedge clk);
    check("to_before", timeout_err, 0);
    @(negedge clk);
    check("to_set", timeout_err, 1);
    repeat (5) @(negedge clk);
    check("to_sticky", timeout_err, 1);
    check("to_still_req", req, 1);
    resp_en = 1'b1;
    wait_idle();
    check("to_after", timeout_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
